sha256_msg_schedule: RTL and testbench

//  Message-schedule stage that sits directly upstream of the SHA-256 round logic.
//  - Accepts one 512-bit padded message block.
//  - Streams the per-round pair (W_t, K_t), t = 0..ROUNDS-1, feeding the round's in_Wi/in_Ki.
//  - Uses a 16-word sliding window, so no 64-word buffer is needed.

---
 rtl/sha256_msg_schedule_pkg.sv | 22 ++
 rtl/sha256_msg_schedule_k_rom.sv | 46 ++++
 rtl/sha256_msg_schedule.sv | 97 +++++++++
 tb/tb_sha256_msg_schedule.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_msg_schedule_pkg.sv
// Shared definitions for the SHA-256 message schedule: FSM encoding, sizes and
// the small sigma functions used to extend the message words.
package sha256_msg_schedule_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int WORD_W = 32;
  localparam int WIN_N  = 16;
  localparam int BLK_W  = WORD_W * WIN_N;

  function automatic logic [WORD_W-1:0] s0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] s1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_k_rom.sv
// Combinational 64-entry ROM of the SHA-256 round constants K[0..63].
module sha256_msg_schedule_k_rom (
  input  logic [5:0]  in_addr,
  output logic [31:0] out_k
);

  always_comb begin
    out_k = '0;
    case (in_addr)
      6'd0:  out_k = 32'h428a2f98; 6'd1:  out_k = 32'h71374491;
      6'd2:  out_k = 32'hb5c0fbcf; 6'd3:  out_k = 32'he9b5dba5;
      6'd4:  out_k = 32'h3956c25b; 6'd5:  out_k = 32'h59f111f1;
      6'd6:  out_k = 32'h923f82a4; 6'd7:  out_k = 32'hab1c5ed5;
      6'd8:  out_k = 32'hd807aa98; 6'd9:  out_k = 32'h12835b01;
      6'd10: out_k = 32'h243185be; 6'd11: out_k = 32'h550c7dc3;
      6'd12: out_k = 32'h72be5d74; 6'd13: out_k = 32'h80deb1fe;
      6'd14: out_k = 32'h9bdc06a7; 6'd15: out_k = 32'hc19bf174;
      6'd16: out_k = 32'he49b69c1; 6'd17: out_k = 32'hefbe4786;
      6'd18: out_k = 32'h0fc19dc6; 6'd19: out_k = 32'h240ca1cc;
      6'd20: out_k = 32'h2de92c6f; 6'd21: out_k = 32'h4a7484aa;
      6'd22: out_k = 32'h5cb0a9dc; 6'd23: out_k = 32'h76f988da;
      6'd24: out_k = 32'h983e5152; 6'd25: out_k = 32'ha831c66d;
      6'd26: out_k = 32'hb00327c8; 6'd27: out_k = 32'hbf597fc7;
      6'd28: out_k = 32'hc6e00bf3; 6'd29: out_k = 32'hd5a79147;
      6'd30: out_k = 32'h06ca6351; 6'd31: out_k = 32'h14292967;
      6'd32: out_k = 32'h27b70a85; 6'd33: out_k = 32'h2e1b2138;
      6'd34: out_k = 32'h4d2c6dfc; 6'd35: out_k = 32'h53380d13;
      6'd36: out_k = 32'h650a7354; 6'd37: out_k = 32'h766a0abb;
      6'd38: out_k = 32'h81c2c92e; 6'd39: out_k = 32'h92722c85;
      6'd40: out_k = 32'ha2bfe8a1; 6'd41: out_k = 32'ha81a664b;
      6'd42: out_k = 32'hc24b8b70; 6'd43: out_k = 32'hc76c51a3;
      6'd44: out_k = 32'hd192e819; 6'd45: out_k = 32'hd6990624;
      6'd46: out_k = 32'hf40e3585; 6'd47: out_k = 32'h106aa070;
      6'd48: out_k = 32'h19a4c116; 6'd49: out_k = 32'h1e376c08;
      6'd50: out_k = 32'h2748774c; 6'd51: out_k = 32'h34b0bcb5;
      6'd52: out_k = 32'h391c0cb3; 6'd53: out_k = 32'h4ed8aa4a;
      6'd54: out_k = 32'h5b9cca4f; 6'd55: out_k = 32'h682e6ff3;
      6'd56: out_k = 32'h748f82ee; 6'd57: out_k = 32'h78a5636f;
      6'd58: out_k = 32'h84c87814; 6'd59: out_k = 32'h8cc70208;
      6'd60: out_k = 32'h90befffa; 6'd61: out_k = 32'ha4506ceb;
      6'd62: out_k = 32'hbef9a3f7; 6'd63: out_k = 32'hc67178f2;
      default: out_k = '0;
    endcase
  end

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block and streams (W_t, K_t) per round
// from a 16-word sliding window.
module sha256_msg_schedule
  import sha256_msg_schedule_pkg::*;
#(
  parameter int ROUNDS  = 64,
  parameter int ROUND_W = 6
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_blk_valid,
  input  logic [BLK_W-1:0]   in_blk,
  output logic               out_blk_ready,
  output logic               out_wk_valid,
  input  logic               in_wk_ready,
  output logic [WORD_W-1:0]  out_Wi,
  output logic [WORD_W-1:0]  out_Ki,
  output logic [ROUND_W-1:0] out_round,
  output logic               out_last,
  output logic               out_done,
  output logic               out_dbg_state
);

  // Both interfaces are valid/ready: a transfer happens on a rising edge where
  // valid && ready; the producer holds its payload stable until that edge.
  state_t              r_state;
  state_t              w_state_nxt;
  logic [WORD_W-1:0]   r_win [WIN_N];
  logic [ROUND_W-1:0]  r_t;
  logic                r_done;
  logic                w_blk_hs;
  logic                w_wk_hs;
  logic                w_last;
  logic [WORD_W-1:0]   w_new;
  logic [WORD_W-1:0]   w_k;
  logic [5:0]          w_k_addr;

  assign w_last   = (r_t == ROUND_W'(ROUNDS - 1));
  assign w_blk_hs = out_blk_ready && in_blk_valid;
  assign w_wk_hs  = out_wk_valid && in_wk_ready;
  assign w_new    = s1(r_win[14]) + r_win[9] + s0(r_win[1]) + r_win[0];
  assign w_k_addr = 6'(r_t);

  sha256_msg_schedule_k_rom u_k_rom (
    .in_addr (w_k_addr),
    .out_k   (w_k)
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    out_blk_ready = 1'b0;
    out_wk_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        out_blk_ready = 1'b1;
        if (in_blk_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        out_wk_valid = 1'b1;
        if (in_wk_ready && w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Round counter stops at the last round; only a fresh load rewinds it.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int k = 0; k < WIN_N; k++) r_win[k] <= '0;
      r_t    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_wk_hs && w_last;
      if (w_blk_hs) begin
        for (int k = 0; k < WIN_N; k++) r_win[k] <= in_blk[BLK_W-1-WORD_W*k -: WORD_W];
        r_t <= '0;
      end else if (w_wk_hs && !w_last) begin
        for (int k = 0; k < WIN_N-1; k++) r_win[k] <= r_win[k+1];
        r_win[WIN_N-1] <= w_new;
        r_t            <= r_t + 1'b1;
      end
    end
  end

  assign out_Wi        = out_wk_valid ? r_win[0] : '0;
  assign out_Ki        = out_wk_valid ? w_k : '0;
  assign out_round     = out_wk_valid ? r_t : '0;
  assign out_last      = out_wk_valid && w_last;
  assign out_done      = r_done;
  assign out_dbg_state = r_state;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: a 64-round and a 16-round instance, directed blocks,
// expected (W,K,round,last) pushed on block acceptance and popped by a monitor.
module tb_sha256_msg_schedule;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 64-round instance
  logic         blk_valid = 1'b0;
  logic [511:0] blk = '0;
  logic         blk_ready;
  logic         wk_valid;
  logic         wk_ready = 1'b1;
  logic [31:0]  wi, ki;
  logic [5:0]   round;
  logic         last, done, dbg_state;

  // 16-round instance
  logic         blk16_valid = 1'b0;
  logic [511:0] blk16 = '0;
  logic         blk16_ready;
  logic         wk16_valid;
  logic         wk16_ready = 1'b1;
  logic [31:0]  wi16, ki16;
  logic [3:0]   round16;
  logic         last16, done16, dbg16_state;

  sha256_msg_schedule #(.ROUNDS(64), .ROUND_W(6)) dut (
    .in_clk(clk), .in_rst(rst), .in_blk_valid(blk_valid), .in_blk(blk),
    .out_blk_ready(blk_ready), .out_wk_valid(wk_valid), .in_wk_ready(wk_ready),
    .out_Wi(wi), .out_Ki(ki), .out_round(round), .out_last(last),
    .out_done(done), .out_dbg_state(dbg_state));

  sha256_msg_schedule #(.ROUNDS(16), .ROUND_W(4)) dut16 (
    .in_clk(clk), .in_rst(rst), .in_blk_valid(blk16_valid), .in_blk(blk16),
    .out_blk_ready(blk16_ready), .out_wk_valid(wk16_valid), .in_wk_ready(wk16_ready),
    .out_Wi(wi16), .out_Ki(ki16), .out_round(round16), .out_last(last16),
    .out_done(done16), .out_dbg_state(dbg16_state));

  int checks = 0;
  int errors = 0;
  int hs64 = 0;
  int hs16 = 0;
  bit rand_ready = 1'b0;
  bit done_pend = 1'b0;
  bit done16_pend = 1'b0;
  logic [70:0] exp_q[$];
  logic [68:0] exp16_q[$];
  logic [31:0] mw [64];

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference schedule, computed in the plain 64-word form
  function automatic logic [31:0] rs0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] rs1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  function automatic void calc_w(input logic [511:0] b);
    for (int t = 0; t < 16; t++) mw[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) mw[t] = rs1(mw[t-2]) + mw[t-7] + rs0(mw[t-15]) + mw[t-16];
  endfunction

  // ready driver
  always @(posedge clk) begin
    #1;
    wk_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // monitor / scoreboard, 64-round instance
  always @(negedge clk) begin
    if (rst) begin
      done_pend = 1'b0;
    end else begin
      chk("done64", {70'h0, done}, {70'h0, done_pend});
      done_pend = 1'b0;
      if (wk_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid64", {70'h0, wk_valid}, 71'h0);
        end else begin
          chk("wk64", {wi, ki, round, last}, exp_q[0]);
          if (wk_ready) begin
            if (exp_q[0][0]) done_pend = 1'b1;
            void'(exp_q.pop_front());
            hs64++;
          end
        end
      end
    end
  end

  // monitor / scoreboard, 16-round instance
  always @(negedge clk) begin
    if (rst) begin
      done16_pend = 1'b0;
    end else begin
      chk("done16", {70'h0, done16}, {70'h0, done16_pend});
      done16_pend = 1'b0;
      if (wk16_valid) begin
        if (exp16_q.size() == 0) begin
          chk("unexpected_valid16", {70'h0, wk16_valid}, 71'h0);
        end else begin
          chk("wk16", {2'b0, wi16, ki16, round16, last16}, {2'b0, exp16_q[0]});
          if (wk16_ready) begin
            if (exp16_q[0][0]) done16_pend = 1'b1;
            void'(exp16_q.pop_front());
            hs16++;
          end
        end
      end
    end
  end

  // offer a block; push its expected rounds at the cycle it is taken
  task automatic send_blk(input bit sel16, input logic [511:0] b, output bit done_at_acc, output int q_left);
    bit ok;
    ok = 1'b0;
    done_at_acc = 1'b0;
    q_left = 0;
    @(posedge clk); #1;
    if (sel16) begin blk16 = b; blk16_valid = 1'b1; end
    else       begin blk = b;   blk_valid = 1'b1;   end
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sel16 ? blk16_ready : blk_ready) begin ok = 1'b1; break; end
    end
    chk("blk_accept_timeout", {70'h0, ok}, 71'h1);
    if (ok) begin
      calc_w(b);
      if (sel16) begin
        q_left = exp16_q.size();
        for (int t = 0; t < 16; t++) exp16_q.push_back({mw[t], K_TAB[t], 4'(t), t == 15});
      end else begin
        q_left = exp_q.size();
        done_at_acc = done;
        for (int t = 0; t < 64; t++) exp_q.push_back({mw[t], K_TAB[t], 6'(t), t == 63});
      end
    end
    @(posedge clk); #1;
    if (sel16) blk16_valid = 1'b0;
    else       blk_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit sel16);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (sel16 ? (exp16_q.size() == 0 && blk16_ready && !wk16_valid)
                : (exp_q.size() == 0 && blk_ready && !wk_valid)) begin
        ok = 1'b1; break;
      end
    end
    chk("idle_timeout", {70'h0, ok}, 71'h1);
  endtask

  // "abc" block with hand-computed spot values
  task automatic run_abc();
    bit acc_done, got_done;
    int ql, base;
    base = hs64;
    got_done = 1'b0;
    send_blk(1'b0, ABC_BLK, acc_done, ql);
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (wk_valid) begin
        case (round)
          6'd0:  begin chk("abc_w0", {39'h0, wi}, {39'h0, 32'h61626380});
                       chk("abc_k0", {39'h0, ki}, {39'h0, 32'h428a2f98}); end
          6'd16: chk("abc_w16", {39'h0, wi}, {39'h0, 32'h61626380});
          6'd17: chk("abc_w17", {39'h0, wi}, {39'h0, 32'h000f0000});
          6'd63: begin chk("abc_k63", {39'h0, ki}, {39'h0, 32'hc67178f2});
                       chk("abc_last63", {70'h0, last}, 71'h1); end
          default: ;
        endcase
      end
      if (done) begin got_done = 1'b1; break; end
    end
    chk("abc_done_seen", {70'h0, got_done}, 71'h1);
    chk("abc_hs_count", 71'(hs64 - base), 71'd64);
    chk("abc_ready_after", {70'h0, blk_ready}, 71'h1);
  endtask

  logic [511:0] blk_b;
  bit acc_done;
  int q_left, base;

  initial begin
    for (int k = 0; k < 16; k++) blk_b[511-32*k -: 32] = 32'h9e3779b9 * (k + 1) ^ 32'h5a5a0000;

    // reset held with a block offered
    blk_valid = 1'b1; blk = ABC_BLK; blk16_valid = 1'b1; blk16 = ABC_BLK;
    repeat (3) begin
      @(negedge clk);
      chk("rst_blk_ready", {70'h0, blk_ready}, 71'h1);
      chk("rst_outputs", {wi, ki, round, last}, 71'h0);
      chk("rst_valid_done", {69'h0, wk_valid, done}, 71'h0);
      chk("rst_blk16_ready", {70'h0, blk16_ready}, 71'h1);
    end
    @(posedge clk); #1;
    blk_valid = 1'b0; blk16_valid = 1'b0;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_load", {69'h0, wk_valid, wk16_valid}, 71'h0);
    end

    // "abc" with ready held high
    run_abc();

    // random backpressure at ~30% ready
    rand_ready = 1'b1;
    base = hs64;
    send_blk(1'b0, ABC_BLK, acc_done, q_left);
    wait_idle(1'b0);
    chk("bp_hs_count", 71'(hs64 - base), 71'd64);
    rand_ready = 1'b0;
    @(posedge clk); #2;

    // back-to-back: B offered while A runs, taken in A's done cycle
    send_blk(1'b0, ABC_BLK, acc_done, q_left);
    send_blk(1'b0, blk_b, acc_done, q_left);
    chk("b2b_accept_in_done", {70'h0, acc_done}, 71'h1);
    chk("b2b_a_drained", 71'(q_left), 71'd0);
    @(negedge clk);
    chk("b2b_round0_valid", {64'h0, wk_valid, round}, {64'h0, 1'b1, 6'd0});
    wait_idle(1'b0);

    // abort mid-run with an asynchronous reset
    base = hs64;
    send_blk(1'b0, ABC_BLK, acc_done, q_left);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (hs64 - base >= 20) break;
    end
    chk("abort_reached_20", {70'h0, (hs64 - base >= 20)}, 71'h1);
    @(posedge clk); #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_rst_outputs", {wi, ki, round, last}, 71'h0);
    chk("abort_rst_ctrl", {68'h0, blk_ready, wk_valid, done}, {68'h0, 3'b100});
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_abc();

    // 16-round instance: W are the raw block words
    base = hs16;
    send_blk(1'b1, blk_b, acc_done, q_left);
    wait_idle(1'b1);
    chk("r16_hs_count", 71'(hs16 - base), 71'd16);
    chk("r16_idle", {69'h0, blk16_ready, wk16_valid}, {69'h0, 2'b10});

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
